// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer for 2-bit words with valid/ready on every side.
// Target channel comes from S or a round-robin pointer; each channel holds one word.

module demux4_reg_ch (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic [1:0] i_din,
   input  logic       i_ready,
   output logic [1:0] o_data,
   output logic       o_valid
);
   logic [1:0] r_data;
   logic       r_valid;

   // Load wins over drain so a same-cycle drain+refill keeps the buffer full.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= 2'b00;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_din;
         r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
endmodule

module demux4_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       EN,
   input  logic       AUTO,
   input  logic [1:0] S,
   input  logic [1:0] DIN,
   input  logic       IN_VALID,
   output logic       IN_READY,
   output logic [1:0] A,
   output logic [1:0] B,
   output logic [1:0] C,
   output logic [1:0] D,
   output logic       A_VALID,
   output logic       B_VALID,
   output logic       C_VALID,
   output logic       D_VALID,
   input  logic       A_READY,
   input  logic       B_READY,
   input  logic       C_READY,
   input  logic       D_READY,
   output logic [1:0] PTR,
   output logic [7:0] TOTAL
);
   localparam int NUM_CH = 4;

   logic [1:0]              r_ptr;
   logic [7:0]              r_total;
   logic [1:0]              w_tgt;
   logic                    w_acc;
   logic [NUM_CH-1:0]       w_v;
   logic [NUM_CH-1:0]       w_r;
   logic [NUM_CH-1:0]       w_load;
   logic [NUM_CH-1:0][1:0]  w_data;

   assign w_r      = {D_READY, C_READY, B_READY, A_READY};
   assign w_tgt    = AUTO ? r_ptr : S;
   // Full target with a stalled consumer blocks input; no steering to another channel.
   assign IN_READY = EN & (~w_v[w_tgt] | w_r[w_tgt]);
   assign w_acc    = IN_VALID & IN_READY;

   genvar k;
   generate
      for (k = 0; k < NUM_CH; k++) begin : g_ch
         assign w_load[k] = w_acc & (w_tgt == k[1:0]);
         demux4_reg_ch u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[k]),
            .i_din   (DIN),
            .i_ready (w_r[k]),
            .o_data  (w_data[k]),
            .o_valid (w_v[k])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr   <= 2'b00;
         r_total <= 8'h00;
      end else if (w_acc) begin
         r_total <= r_total + 8'd1;
         if (AUTO) r_ptr <= r_ptr + 2'd1;
      end
   end

   assign A       = w_data[0];
   assign B       = w_data[1];
   assign C       = w_data[2];
   assign D       = w_data[3];
   assign A_VALID = w_v[0];
   assign B_VALID = w_v[1];
   assign C_VALID = w_v[2];
   assign D_VALID = w_v[3];
   assign PTR     = r_ptr;
   assign TOTAL   = r_total;
endmodule

// File: tb/tb_demux4_reg.sv
// Directed self-checking bench for demux4_reg: select, backpressure, round-robin,
// enable gating, TOTAL wrap and mid-stream reset.

module tb_demux4_reg;
   logic       clk = 1'b0;
   logic       rst, EN, AUTO, IN_VALID, IN_READY;
   logic [1:0] S, DIN, A, B, C, D, PTR;
   logic       A_VALID, B_VALID, C_VALID, D_VALID;
   logic       A_READY, B_READY, C_READY, D_READY;
   logic [7:0] TOTAL;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   demux4_reg dut (
      .clk(clk), .rst(rst), .EN(EN), .AUTO(AUTO), .S(S), .DIN(DIN),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .A(A), .B(B), .C(C), .D(D),
      .A_VALID(A_VALID), .B_VALID(B_VALID), .C_VALID(C_VALID), .D_VALID(D_VALID),
      .A_READY(A_READY), .B_READY(B_READY), .C_READY(C_READY), .D_READY(D_READY),
      .PTR(PTR), .TOTAL(TOTAL)
   );

   wire [3:0] w_valids = {D_VALID, C_VALID, B_VALID, A_VALID};
   wire [7:0] w_datas  = {D, C, B, A};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; IN_VALID = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      EN = 1'b1; AUTO = 1'b0; S = 2'b00; DIN = 2'b00;
      {D_READY, C_READY, B_READY, A_READY} = 4'b0000;
      do_reset();
      checks++; if (w_valids !== 4'b0000) begin failures++; $display("FAIL reset_valids got=%b exp=0000", w_valids); end
      checks++; if (w_datas !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", w_datas); end
      checks++; if (PTR !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", PTR); end
      checks++; if (TOTAL !== 8'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", TOTAL); end
      checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
   endtask

   task automatic test_select();
      S = 2'b10; DIN = 2'b11; IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      checks++; if (C !== 2'b11) begin failures++; $display("FAIL select_c_data got=%b exp=11", C); end
      checks++; if (w_valids !== 4'b0100) begin failures++; $display("FAIL select_valids got=%b exp=0100", w_valids); end
      checks++; if (TOTAL !== 8'd1) begin failures++; $display("FAIL select_total got=%0d exp=1", TOTAL); end
   endtask

   task automatic test_backpressure();
      S = 2'b10; DIN = 2'b01; IN_VALID = 1'b1; C_READY = 1'b0;
      #1;
      checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low got=%b exp=0", IN_READY); end
      tick();
      checks++; if (C !== 2'b11) begin failures++; $display("FAIL bp_c_hold got=%b exp=11", C); end
      checks++; if (TOTAL !== 8'd1) begin failures++; $display("FAIL bp_total_hold got=%0d exp=1", TOTAL); end
      C_READY = 1'b1;
      #1;
      checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL bp_in_ready_high got=%b exp=1", IN_READY); end
      tick();
      IN_VALID = 1'b0;
      checks++; if (C !== 2'b01 || C_VALID !== 1'b1) begin failures++; $display("FAIL bp_refill got=%b/%b exp=01/1", C, C_VALID); end
      checks++; if (TOTAL !== 8'd2) begin failures++; $display("FAIL bp_total got=%0d exp=2", TOTAL); end
      tick();
      // drain without refill: valid drops, data register keeps its word
      checks++; if (C_VALID !== 1'b0 || C !== 2'b01) begin failures++; $display("FAIL bp_drain got=%b/%b exp=01/0", C, C_VALID); end
      C_READY = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [1:0] words [5];
      logic [1:0] got;
      words = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
      do_reset();
      AUTO = 1'b1; {D_READY, C_READY, B_READY, A_READY} = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         DIN = words[i]; IN_VALID = 1'b1;
         tick();
         case (i % 4)
            0: got = A;
            1: got = B;
            2: got = C;
            default: got = D;
         endcase
         checks++; if (got !== words[i] || w_valids[i%4] !== 1'b1) begin failures++; $display("FAIL rr_word%0d got=%b/%b exp=%b/1", i, got, w_valids[i%4], words[i]); end
         checks++; if (PTR !== 2'((i + 1) % 4)) begin failures++; $display("FAIL rr_ptr%0d got=%0d exp=%0d", i, PTR, (i + 1) % 4); end
      end
      IN_VALID = 1'b0;
      checks++; if (TOTAL !== 8'd5) begin failures++; $display("FAIL rr_total got=%0d exp=5", TOTAL); end
   endtask

   task automatic test_enable();
      AUTO = 1'b0; {D_READY, C_READY, B_READY, A_READY} = 4'b0000;
      S = 2'b01; DIN = 2'b10; IN_VALID = 1'b1;
      tick();  // B loaded: TOTAL=6, PTR stays 1
      EN = 1'b0; DIN = 2'b11; B_READY = 1'b1; AUTO = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL en_in_ready%0d got=%b exp=0", i, IN_READY); end
         tick();
         checks++; if (TOTAL !== 8'd6 || PTR !== 2'd1) begin failures++; $display("FAIL en_hold%0d got=%0d/%0d exp=6/1", i, TOTAL, PTR); end
         checks++; if (B_VALID !== 1'b0 || B !== 2'b10) begin failures++; $display("FAIL en_b_drain%0d got=%b/%b exp=10/0", i, B, B_VALID); end
      end
      IN_VALID = 1'b0; EN = 1'b1; B_READY = 1'b0;
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      AUTO = 1'b1; {D_READY, C_READY, B_READY, A_READY} = 4'b1111;
      IN_VALID = 1'b1;
      for (int i = 0; i < 256; i++) begin
         DIN = 2'(i);
         tick();
         if (i == 254) begin
            checks++; if (TOTAL !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", TOTAL); end
         end
      end
      IN_VALID = 1'b0;
      checks++; if (TOTAL !== 8'd0) begin failures++; $display("FAIL wrap_total got=%0d exp=0", TOTAL); end
      checks++; if (PTR !== 2'd0) begin failures++; $display("FAIL wrap_ptr got=%0d exp=0", PTR); end
      // A holds a word, then reset with an accept to B presented
      AUTO = 1'b0; {D_READY, C_READY, B_READY, A_READY} = 4'b0000;
      S = 2'b00; DIN = 2'b01; IN_VALID = 1'b1;
      tick();
      checks++; if (A_VALID !== 1'b1 || A !== 2'b01 || TOTAL !== 8'd1) begin failures++; $display("FAIL pre_rst got=%b/%b/%0d exp=01/1/1", A, A_VALID, TOTAL); end
      S = 2'b01; DIN = 2'b10; rst = 1'b1;
      #1;
      checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL rst_accept_presented got=%b exp=1", IN_READY); end
      tick();
      rst = 1'b0; IN_VALID = 1'b0;
      checks++; if (w_valids !== 4'b0000) begin failures++; $display("FAIL rst_valids got=%b exp=0000", w_valids); end
      checks++; if (PTR !== 2'd0 || TOTAL !== 8'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", PTR, TOTAL); end
      checks++; if (A !== 2'b00 || B !== 2'b00) begin failures++; $display("FAIL rst_no_deliver got=%b/%b exp=00/00", A, B); end
   endtask

   initial begin
      rst = 1'b1; EN = 1'b1; AUTO = 1'b0; S = 2'b00; DIN = 2'b00; IN_VALID = 1'b0;
      {D_READY, C_READY, B_READY, A_READY} = 4'b0000;
      test_reset();
      test_select();
      test_backpressure();
      test_round_robin();
      test_enable();
      test_wrap_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/demux4_reg.md
# demux4_reg

Registered 1-to-4 demultiplexer for 2-bit words: the distribution side of the four-channel 2-bit selector path. Each accepted input word is steered to channel A, B, C or D and held there in a single-entry output buffer until that channel's consumer takes it. The target channel comes from an explicit select or from an internal round-robin pointer. The block sits between a single 2-bit producer and four independent 2-bit consumers, with valid/ready flow control on every side.

## Interface
- No parameters; all data paths are fixed at 2 bits and there are 4 channels.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- EN  in  1  block enable; 0 blocks new input acceptance
- AUTO  in  1  1 = round-robin steering, 0 = steering by S
- S  in  2  channel select when AUTO=0 (00=A, 01=B, 10=C, 11=D)
- DIN  in  2  input word
- IN_VALID  in  1  DIN is valid
- IN_READY  out  1  block will accept DIN this cycle
- A, B, C, D  out  2 each  channel output words
- A_VALID, B_VALID, C_VALID, D_VALID  out  1 each  channel buffer holds a word
- A_READY, B_READY, C_READY, D_READY  in  1 each  channel consumer takes the word
- PTR  out  2  current round-robin pointer
- TOTAL  out  8  count of accepted input words, modulo 256

## Operation
- Target channel t = PTR when AUTO=1; t = S when AUTO=0.
- IN_READY = EN & (~V[t] | R[t]). This is combinational from EN, AUTO, S, PTR, the channel valids and the channel readies.
- Accept event: IN_VALID & IN_READY.
- On accept:
  - buffer[t] <= DIN; V[t] <= 1.
  - TOTAL <= TOTAL+1, wrapping 255 -> 0.
  - If AUTO=1, PTR <= PTR+1, wrapping 3 -> 0.
- Drain event on channel k: V[k] & R[k].
- Drain without refill on the same channel: V[k] <= 0. The data register keeps its last value.
- Drain and refill on the same channel in the same cycle: V stays 1 and the new word replaces the old one. No bubble, no loss.
- The four channels drain independently. Any subset may drain in the same cycle.
- Channel outputs are driven only from their registers. A non-selected channel never changes value.
- EN=0:
  - IN_READY=0, so no accepts.
  - PTR and TOTAL hold.
  - Buffered words keep presenting and may still drain.
- AUTO=0:
  - PTR holds its value.
  - Switching AUTO 1 -> 0 -> 1 resumes round-robin from the held PTR.
- Changing S while IN_VALID=1 is legal. The target is evaluated per cycle.
- When the target buffer is full and its consumer is not ready, IN_READY=0. The producer stalls, and other channels are not used in its place (no reordering).
- DIN is ignored when IN_VALID=0 or when IN_READY=0.

## Timing
- Reset (rst=1 at a clk edge):
  - A, B, C, D = 00.
  - All *_VALID = 0.
  - PTR = 00, TOTAL = 0x00.
  - IN_READY follows its equation: 1 after reset if EN=1.
- rst takes priority over accept and drain in the same cycle. An accept presented in the reset cycle is discarded and not counted.
- Reset asserted mid-stream flushes all buffered words.
- Latency: a word accepted at edge n appears on its channel with VALID=1 from edge n, i.e. visible in cycle n+1.
- Sustained throughput is 1 word/clk to any channel whose consumer holds READY=1.
- There is no combinational path from DIN to the channel outputs.

## Test plan
- Reset then select mode:
  - Stimulus: rst 2 cycles; EN=1, AUTO=0, S=10, DIN=11, IN_VALID=1 for 1 cycle; all readies 0.
  - Required: next cycle C=11, C_VALID=1, others invalid, TOTAL=1.
- Backpressure:
  - Stimulus: with C holding a word and C_READY=0, present S=10, DIN=01.
  - Required: IN_READY=0; C stays 11; TOTAL unchanged.
  - Then raise C_READY: the same-cycle accept leaves C=01 with C_VALID still 1.
- Round-robin:
  - Stimulus: AUTO=1, all readies 1, stream DIN=00,01,10,11,00.
  - Required: words land on A, B, C, D, A; PTR goes 1, 2, 3, 0, 1; TOTAL=5.
- Enable gating:
  - Stimulus: EN=0 with IN_VALID=1 for 3 cycles while B holds a word and B_READY=1.
  - Required: IN_READY=0; TOTAL and PTR hold; B_VALID falls after one cycle.
- TOTAL wrap and reset mid-stream:
  - Stimulus: 256 accepts.
  - Required: TOTAL=0x00.
  - Then assert rst while A_VALID=1 and an accept is presented: all valids 0, PTR=0, TOTAL=0, and the word is not delivered.
